noc_fault_event_decoder: RTL
============================

# noc_fault_event_decoder

Receive-side decoder for NoC fault event packets on the debug interconnect (DII). It accepts the event packets generated by the NoC control module's fault-detection submodule (SUB_ID 2'b00), checks the header, and rebuilds the per-node 8-bit fault vector. Packets may be split across several DII packets by the sender; the decoder stitches them together. It publishes a complete, coherent snapshot with a one-cycle update strobe. It sits between the debug ring egress and host-side or on-chip fault monitoring logic.

## Interface
- X, 3: mesh width.
- Y, 3: mesh height; X*Y ≤ 18, otherwise elaboration fails with $fatal.
- MAX_DI_PKT_LEN, 12: maximum DII packet length in flits; MAX_PAYLOAD_LEN = MAX_DI_PKT_LEN-4.
- NODES (localparam) = X*Y.
- clk  in  1  single clock.
- rst_n  in  1  reset: asynchronous assert, active-low.
- id  in  16  this decoder's DII address; packets with another destination are discarded.
- in  in  dii_flit  {valid, last, data[15:0]} event stream.
- in_ready  out  1  0 while in reset; 1 from the first clk edge after rst_n deasserts. The decoder never back-pressures.
- faults_out  out  [NODES-1:0][7:0]  last committed fault snapshot; reset 0.
- faults_update  out  1  one-cycle pulse when faults_out changes; reset 0.
- faults_src  out  16  source ID of the committed snapshot; reset 0.
- err_cnt  out  16  count of malformed packets, saturating at 16'hFFFF; reset 0.

## Operation
- A flit is accepted when in.valid & in_ready. State changes only on accepted flits.
- States: S_DEST, S_SRC, S_FLAGS, S_ID, S_XFER, S_DROP. Reset state is S_DEST.
- Runt rule: `last` on a flit accepted in S_DEST, S_SRC, S_FLAGS or S_ID → err_cnt+1, go to S_DEST.
- S_DEST: data≠id → S_DROP with no error; otherwise go to S_SRC.
- S_SRC: latch pkt_src = data, then go to S_FLAGS.
- S_FLAGS: data[15:14]≠2'b10 or data[13:10]≠4'b0000 → err, S_DROP. Otherwise go to S_ID.
- S_ID: data[1:0]≠2'b00 → S_DROP with no error (packet belongs to another submodule). Otherwise idx = data[15:2].
  - idx==0: clear the shadow vector, set expected=0, snap_src=pkt_src, go to S_XFER.
  - idx≠expected, idx odd, idx≥NODES, or (idx≠0 and pkt_src≠snap_src) → err, expected=0, S_DROP.
  - Otherwise go to S_XFER.
  - payload_cnt=0 on entry to S_XFER.
- S_XFER, per flit:
  - Write shadow[idx]=data[7:0].
  - If idx+1<NODES, write shadow[idx+1]=data[15:8]. The high byte is ignored when idx==NODES-1.
  - Advance idx+=2 and payload_cnt+=1.
  - Final flit (idx+2≥NODES) with last: commit shadow, including this flit's bytes, to faults_out; faults_src=snap_src; expected=0; go to S_DEST.
  - Final flit without last → err, expected=0, S_DROP.
  - Non-final flit with last: expected=idx+2, go to S_DEST to await the continuation packet.
  - Non-final flit without last when payload_cnt reaches MAX_PAYLOAD_LEN → err, expected=0, S_DROP.
- S_DROP: consume flits until `last`, then go to S_DEST.
- A new idx==0 packet always restarts reassembly and discards any partial shadow.
- Arithmetic: idx is a $clog2(NODES)+1-bit register, so idx+2 does not wrap. err_cnt increments at most once per packet.

## Timing
- faults_out and faults_src update on the clk edge that accepts the final flit.
- faults_update is high exactly during the cycle after that edge. Back-to-back commits produce back-to-back pulses.
- faults_out is never partially updated; the shadow is not visible externally.
- rst_n low at any time, including mid-packet: all outputs and state return to reset values immediately. The next flit is interpreted as a DEST flit.
- Throughput: one flit per cycle sustained.

## Test plan
- 3x3, id=0x0001: flits 0001, 0005, 8000, 0000, 0201, 0403, 0605, 0807, last 0009. Required: faults_out[n]=n+1, faults_src=0x0005, one faults_update pulse one cycle after the last flit, err_cnt=0.
- MAX_DI_PKT_LEN=6, three packets with ID flits 0000 (payload 0201, last 0403), 0010 (0605, last 0807), 0020 (last 0009). Required: faults_update pulses only after the third packet, with the same vector as the first scenario.
- Flags flit 4000, or last on the SRC flit. Required: err_cnt=1, faults_out unchanged, no pulse. A following valid packet decodes correctly.
- Continuation with ID 0020 when expected=4, or with a different src. Required: err_cnt+1, no commit. A subsequent idx=0 packet commits normally.
- Packet with dest 0x0002, and a packet with SUB_ID flit 0x0001. Required: both consumed silently, err_cnt=0, in_ready stays 1.
- rst_n pulsed low after the third payload flit. Required: all outputs 0 during reset, in_ready 0 until the first edge after release. A complete packet afterwards commits correctly.

Source files
------------

// File: rtl/noc_fault_event_decoder.sv
// noc_fault_event_decoder
// Receive-side decoder for NoC fault event packets arriving on the debug
// interconnect. It checks the packet header and rebuilds the per-node 8-bit
// fault vector, stitching continuation packets together. It then publishes a
// coherent snapshot with a one-cycle update strobe.
//
// Ports
//   clk           single clock
//   rst_n         asynchronous active-low reset
//   id            this decoder's DII address
//   in            event flit stream, packed {valid[17], last[16], data[15:0]}
//   in_ready      low in reset, high from the first clk edge after release
//   faults_out    last committed fault snapshot, one byte per node
//   faults_update one-cycle pulse after each commit
//   faults_src    source ID of the committed snapshot
//   err_cnt       saturating count of malformed packets
module noc_fault_event_decoder #(
    parameter int unsigned X              = 3,
    parameter int unsigned Y              = 3,
    parameter int unsigned MAX_DI_PKT_LEN = 12,
    localparam int unsigned NODES         = X * Y
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           id,
    input  logic [17:0]           in,
    output logic                  in_ready,
    output logic [NODES-1:0][7:0] faults_out,
    output logic                  faults_update,
    output logic [15:0]           faults_src,
    output logic [15:0]           err_cnt
);

    localparam int unsigned IW              = $clog2(NODES) + 1;
    localparam int unsigned MAX_PAYLOAD_LEN = MAX_DI_PKT_LEN - 4;
    localparam int unsigned CW              = $clog2(MAX_PAYLOAD_LEN + 1);

    // Snapshot storage is sized for at most 18 nodes.
    if (NODES > 18) begin : g_size_check
        $fatal(1, "noc_fault_event_decoder: X*Y must not exceed 18");
    end

    typedef enum logic [2:0] {
        S_DEST,
        S_SRC,
        S_FLAGS,
        S_ID,
        S_XFER,
        S_DROP
    } state_t;

    state_t                state, state_nxt;
    logic [15:0]           pkt_src, pkt_src_nxt;
    logic [15:0]           snap_src, snap_src_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [IW-1:0]         expected, expected_nxt;
    logic [CW-1:0]         payload_cnt, payload_cnt_nxt;
    logic [NODES-1:0][7:0] shadow, shadow_nxt;
    logic [NODES-1:0][7:0] faults_out_nxt;
    logic [15:0]           faults_src_nxt;
    logic                  faults_update_nxt;
    logic [15:0]           err_cnt_nxt;

    logic                  in_valid, in_last;
    logic [15:0]           in_data;
    logic [13:0]           d_idx;
    logic                  accept;
    logic                  err_inc;
    logic [IW-1:0]         idx_hi, idx_sum;
    logic [CW-1:0]         cnt_sum;

    assign in_valid = in[17];
    assign in_last  = in[16];
    assign in_data  = in[15:0];
    assign d_idx    = in[15:2];
    assign accept   = in_valid & in_ready;
    assign idx_hi   = idx + IW'(1);
    assign idx_sum  = idx + IW'(2);
    assign cnt_sum  = payload_cnt + CW'(1);

    // Packet parser, reassembly and commit decision.
    always_comb begin
        state_nxt         = state;
        pkt_src_nxt       = pkt_src;
        snap_src_nxt      = snap_src;
        idx_nxt           = idx;
        expected_nxt      = expected;
        payload_cnt_nxt   = payload_cnt;
        shadow_nxt        = shadow;
        faults_out_nxt    = faults_out;
        faults_src_nxt    = faults_src;
        faults_update_nxt = 1'b0;
        err_inc           = 1'b0;

        if (accept) begin
            // A header cut short by 'last' is a runt regardless of its content.
            if (in_last && (state == S_DEST || state == S_SRC ||
                            state == S_FLAGS || state == S_ID)) begin
                err_inc   = 1'b1;
                state_nxt = S_DEST;
            end else begin
                case (state)
                    S_DEST: state_nxt = (in_data == id) ? S_SRC : S_DROP;
                    S_SRC: begin
                        pkt_src_nxt = in_data;
                        state_nxt   = S_FLAGS;
                    end
                    S_FLAGS: begin
                        if (in_data[15:14] != 2'b10 || in_data[13:10] != 4'b0000) begin
                            err_inc   = 1'b1;
                            state_nxt = S_DROP;
                        end else begin
                            state_nxt = S_ID;
                        end
                    end
                    S_ID: begin
                        payload_cnt_nxt = '0;
                        if (in_data[1:0] != 2'b00) begin
                            state_nxt = S_DROP;
                        end else if (d_idx == 14'd0) begin
                            // Start of a new snapshot: any partial shadow is discarded.
                            shadow_nxt   = '0;
                            expected_nxt = '0;
                            snap_src_nxt = pkt_src;
                            idx_nxt      = '0;
                            state_nxt    = S_XFER;
                        end else if (d_idx != 14'(expected) || d_idx[0] ||
                                     d_idx >= 14'(NODES) || pkt_src != snap_src) begin
                            err_inc      = 1'b1;
                            expected_nxt = '0;
                            state_nxt    = S_DROP;
                        end else begin
                            idx_nxt   = IW'(d_idx);
                            state_nxt = S_XFER;
                        end
                    end
                    S_XFER: begin
                        // Low byte to node idx, high byte to idx+1 if that node exists.
                        for (int unsigned n = 0; n < NODES; n++) begin
                            if (IW'(n) == idx) begin
                                shadow_nxt[n] = in_data[7:0];
                            end else if (IW'(n) == idx_hi) begin
                                shadow_nxt[n] = in_data[15:8];
                            end
                        end
                        idx_nxt         = idx_sum;
                        payload_cnt_nxt = cnt_sum;
                        if (idx_sum >= IW'(NODES)) begin
                            expected_nxt = '0;
                            if (in_last) begin
                                faults_out_nxt    = shadow_nxt;
                                faults_src_nxt    = snap_src;
                                faults_update_nxt = 1'b1;
                                state_nxt         = S_DEST;
                            end else begin
                                err_inc   = 1'b1;
                                state_nxt = S_DROP;
                            end
                        end else if (in_last) begin
                            expected_nxt = idx_sum;
                            state_nxt    = S_DEST;
                        end else if (cnt_sum >= CW'(MAX_PAYLOAD_LEN)) begin
                            err_inc      = 1'b1;
                            expected_nxt = '0;
                            state_nxt    = S_DROP;
                        end
                    end
                    S_DROP: begin
                        if (in_last) begin
                            state_nxt = S_DEST;
                        end
                    end
                    default: state_nxt = S_DEST;
                endcase
            end
        end

        err_cnt_nxt = (err_inc && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_DEST;
            pkt_src       <= '0;
            snap_src      <= '0;
            idx           <= '0;
            expected      <= '0;
            payload_cnt   <= '0;
            shadow        <= '0;
            faults_out    <= '0;
            faults_src    <= '0;
            faults_update <= 1'b0;
            err_cnt       <= '0;
            in_ready      <= 1'b0;
        end else begin
            state         <= state_nxt;
            pkt_src       <= pkt_src_nxt;
            snap_src      <= snap_src_nxt;
            idx           <= idx_nxt;
            expected      <= expected_nxt;
            payload_cnt   <= payload_cnt_nxt;
            shadow        <= shadow_nxt;
            faults_out    <= faults_out_nxt;
            faults_src    <= faults_src_nxt;
            faults_update <= faults_update_nxt;
            err_cnt       <= err_cnt_nxt;
            in_ready      <= 1'b1;
        end
    end

endmodule
